uart_boot_loader: RTL and testbench

- Host-facing consumer of the UART byte stream. It pops bytes from the UART receive FIFO and decodes framed load/jump packets.
- Each decoded data word is written into instruction/data memory. Each packet is answered with a one-byte ACK or NAK pushed into the UART transmit FIFO.
- Sits between the uart block and the memory write port. It drives the CPU start PC and releases the core after a JUMP command.

---
 rtl/uart_boot_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: decodes SYNC/CMD/ADDR/LEN/DATA/SUM packets from the RX FIFO,
// writes data words to memory, answers ACK/NAK on TX and launches the core on JUMP.
//
// state  | meaning
// IDLE   | discard bytes until SYNC
// CMD    | command byte, restarts checksum
// ADDR   | four address bytes, MSB first
// LEN    | word count
// DATA   | LEN x 4 data bytes, one memory write per word
// SUM    | checksum byte, decides ACK/NAK
// RESP   | one-cycle response push
module uart_boot_loader #(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_avail,
  input  logic [7:0]  rx_data,
  output logic        rx_en,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        boot_go,
  output logic [31:0] boot_pc,
  output logic        busy
);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_JUMP  = 8'h02;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_SUM, S_RESP
  } state_t;

  state_t      state, state_next;
  logic [1:0]  hold;
  logic [31:0] tcnt;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [7:0]  sum;
  logic [1:0]  bcnt;
  logic [7:0]  widx;
  logic [23:0] wbuf;
  logic        resp_ack;
  logic        resp_go;
  logic        pop;
  logic        waiting;
  logic        tmo;
  logic        jump_len_ok;

  assign jump_len_ok = (cmd != CMD_JUMP) || (len == 8'd0);

  always_comb begin
    state_next = state;
    pop        = !rst && (state != S_RESP) && rx_avail && (hold == 2'd0);
    waiting    = (state inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_SUM}) && !rx_avail;
    tmo        = waiting && ((tcnt + 32'd1) == TIMEOUT);
    case (state)
      S_IDLE: if (pop && rx_data == SYNC) state_next = S_CMD;
      S_CMD: begin
        if (pop) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_JUMP) state_next = S_ADDR;
          else state_next = S_RESP;
        end
      end
      S_ADDR: if (pop && bcnt == 2'd3) state_next = S_LEN;
      S_LEN: begin
        if (pop) state_next = (rx_data == 8'd0) ? S_SUM : S_DATA;
      end
      S_DATA: if (pop && bcnt == 2'd3 && widx == len - 8'd1) state_next = S_SUM;
      S_SUM: if (pop) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // waiting implies rx_avail low, so a pop and an expiry never coincide
    if (tmo) state_next = S_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= 2'd0;
      tcnt      <= 32'd0;
      cmd       <= 8'd0;
      addr      <= 32'd0;
      len       <= 8'd0;
      sum       <= 8'd0;
      bcnt      <= 2'd0;
      widx      <= 8'd0;
      wbuf      <= 24'd0;
      resp_ack  <= 1'b0;
      resp_go   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      boot_pc   <= 32'd0;
    end else begin
      state   <= state_next;
      mem_wen <= 1'b0;
      if (pop) hold <= 2'd2;
      else if (hold != 2'd0) hold <= hold - 2'd1;
      if (pop || tmo) tcnt <= 32'd0;
      else if (waiting) tcnt <= tcnt + 32'd1;
      if (tmo) begin
        resp_ack <= 1'b0;
        resp_go  <= 1'b0;
      end
      if (pop) begin
        case (state)
          S_CMD: begin
            cmd      <= rx_data;
            sum      <= rx_data;
            bcnt     <= 2'd0;
            resp_ack <= 1'b0;
            resp_go  <= 1'b0;
          end
          S_ADDR: begin
            addr <= {addr[23:0], rx_data};
            sum  <= sum + rx_data;
            bcnt <= bcnt + 2'd1;
          end
          S_LEN: begin
            len  <= rx_data;
            sum  <= sum + rx_data;
            bcnt <= 2'd0;
            widx <= 8'd0;
          end
          S_DATA: begin
            sum  <= sum + rx_data;
            wbuf <= {wbuf[15:0], rx_data};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              mem_wen   <= 1'b1;
              mem_addr  <= addr + {22'd0, widx, 2'b00};
              mem_wdata <= {wbuf, rx_data};
              widx      <= widx + 8'd1;
            end
          end
          S_SUM: begin
            resp_ack <= (rx_data == sum) && jump_len_ok;
            resp_go  <= (rx_data == sum) && (cmd == CMD_JUMP) && (len == 8'd0);
            if ((rx_data == sum) && (cmd == CMD_JUMP) && (len == 8'd0)) boot_pc <= addr;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_en   = pop;
  assign tx_en   = (state == S_RESP);
  assign tx_data = (state == S_RESP) ? (resp_ack ? ACK : NAK) : 8'h00;
  assign boot_go = (state == S_RESP) && resp_go;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: a queue-backed RX FIFO model feeds packets,
// a negedge monitor records pops, memory writes, responses and boot pulses.
module tb_uart_boot_loader;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_avail = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_en, tx_en, mem_wen, boot_go, busy;
  logic [7:0]  tx_data;
  logic [31:0] mem_addr, mem_wdata, boot_pc;

  uart_boot_loader #(.TIMEOUT(32'd100), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_avail(rx_avail), .rx_data(rx_data), .rx_en(rx_en),
    .tx_en(tx_en), .tx_data(tx_data), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .boot_go(boot_go), .boot_pc(boot_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rx_q[$];
  int          rd = 0;
  logic        pop_flag = 1'b0;

  int          cyc = 0;
  int          last_pop = -100;
  int          gap_bad = 0;
  int          gap3 = 0;
  int          wen_lat_bad = 0;
  int          tx_lat = 0;
  int          busy_hi = 0;
  int          go_cnt = 0;
  logic [31:0] go_pc = 32'd0;
  logic        go_tx = 1'b0;
  logic [63:0] wq[$];
  logic [7:0]  tq[$];

  // FIFO model: pop decided at negedge, head advances just after the edge
  always @(posedge clk) begin
    #1;
    if (pop_flag) rd++;
    rx_avail = (rd < rx_q.size());
    rx_data  = rx_avail ? rx_q[rd] : 8'h00;
  end

  always @(negedge clk) begin
    cyc++;
    if (mem_wen) begin
      wq.push_back({mem_addr, mem_wdata});
      if (cyc - last_pop != 1) wen_lat_bad++;
    end
    if (tx_en) begin
      tq.push_back(tx_data);
      tx_lat = cyc - last_pop;
    end
    if (boot_go) begin
      go_cnt++;
      go_pc = boot_pc;
      go_tx = tx_en;
    end
    if (busy) busy_hi++;
    if (rx_en) begin
      if (cyc - last_pop < 3) gap_bad++;
      else if (cyc - last_pop == 3) gap3++;
      last_pop = cyc;
    end
    pop_flag = rx_en;
  end

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic push_pkt(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [7:0] sum_adj);
    logic [7:0]  s;
    logic [31:0] w;
    s = cmd + addr[31:24] + addr[23:16] + addr[15:8] + addr[7:0] + len;
    push_byte(8'hA5);
    push_byte(cmd);
    push_byte(addr[31:24]);
    push_byte(addr[23:16]);
    push_byte(addr[15:8]);
    push_byte(addr[7:0]);
    push_byte(len);
    for (int i = 0; i < int'(len); i++) begin
      w = (i == 0) ? w0 : w1;
      for (int b = 3; b >= 0; b--) begin
        push_byte(w[b*8 +: 8]);
        s = s + w[b*8 +: 8];
      end
    end
    push_byte(s + sum_adj);
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (tq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (tq.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: no response within %0d cycles (got %0d responses, need %0d)", name, budget, tq.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_en, tx_en, mem_wen, boot_go, busy, tx_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {rx_en, tx_en, mem_wen, boot_go, busy, tx_data});
    end
    checks++;
    if ({mem_addr, mem_wdata, boot_pc} !== 96'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata, boot_pc});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write_good();
    int t0, w0, g0, gb0, wb0;
    t0 = tq.size(); w0 = wq.size(); g0 = gap3; gb0 = gap_bad; wb0 = wen_lat_bad;
    push_pkt(8'h01, 32'h0000_1000, 8'd2, 32'hDEAD_BEEF, 32'h0102_0304, 8'd0);
    wait_tx(t0 + 1, 400, "wr_good_wait");
    checks++;
    if (wq.size() - w0 !== 2) begin errors++; $display("FAIL wr_count: got %0d expected 2", wq.size() - w0); end
    checks++;
    if (wq[w0] !== {32'h0000_1000, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_word0: got %h expected %h", wq[w0], {32'h0000_1000, 32'hDEAD_BEEF});
    end
    checks++;
    if (wq[w0+1] !== {32'h0000_1004, 32'h0102_0304}) begin
      errors++; $display("FAIL wr_word1: got %h expected %h", wq[w0+1], {32'h0000_1004, 32'h0102_0304});
    end
    checks++;
    if (tq[t0] !== 8'h06) begin errors++; $display("FAIL wr_ack: got %h expected 06", tq[t0]); end
    checks++;
    if (tx_lat !== 1) begin errors++; $display("FAIL wr_tx_latency: got %0d expected 1", tx_lat); end
    checks++;
    if (wen_lat_bad !== wb0) begin errors++; $display("FAIL wr_wen_latency: got %0d late writes expected 0", wen_lat_bad - wb0); end
    checks++;
    if (gap_bad !== gb0) begin errors++; $display("FAIL pop_spacing: got %0d short gaps expected 0", gap_bad - gb0); end
    checks++;
    if (gap3 - g0 !== 15) begin errors++; $display("FAIL pop_back_to_back: got %0d gaps of 3 expected 15", gap3 - g0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_write_badsum();
    int t0, w0, gc0;
    t0 = tq.size(); w0 = wq.size(); gc0 = go_cnt;
    push_pkt(8'h01, 32'h0000_1000, 8'd2, 32'hDEAD_BEEF, 32'h0102_0304, 8'd1);
    wait_tx(t0 + 1, 400, "bad_sum_wait");
    checks++;
    if (wq.size() - w0 !== 2 || wq[w0+1] !== {32'h0000_1004, 32'h0102_0304}) begin
      errors++; $display("FAIL bad_sum_writes: got %0d writes, last %h expected 2, %h", wq.size() - w0, wq[w0+1], {32'h0000_1004, 32'h0102_0304});
    end
    checks++;
    if (tq[t0] !== 8'h15) begin errors++; $display("FAIL bad_sum_nak: got %h expected 15", tq[t0]); end
    checks++;
    if (go_cnt !== gc0) begin errors++; $display("FAIL bad_sum_go: got %0d pulses expected 0", go_cnt - gc0); end
  endtask

  task automatic test_jump();
    int t0, w0, gc0;
    t0 = tq.size(); w0 = wq.size(); gc0 = go_cnt;
    push_pkt(8'h02, 32'h8000_0000, 8'd0, 32'd0, 32'd0, 8'd0);
    wait_tx(t0 + 1, 200, "jump_wait");
    checks++;
    if (tq[t0] !== 8'h06) begin errors++; $display("FAIL jump_ack: got %h expected 06", tq[t0]); end
    checks++;
    if (go_cnt - gc0 !== 1 || go_pc !== 32'h8000_0000 || go_tx !== 1'b1) begin
      errors++; $display("FAIL jump_go: got pulses=%0d pc=%h with_tx=%b expected 1 80000000 1", go_cnt - gc0, go_pc, go_tx);
    end
    checks++;
    if (wq.size() !== w0) begin errors++; $display("FAIL jump_no_write: got %0d writes expected 0", wq.size() - w0); end

    t0 = tq.size(); w0 = wq.size(); gc0 = go_cnt;
    push_pkt(8'h02, 32'h0000_2000, 8'd1, 32'h1122_3344, 32'd0, 8'd0);
    wait_tx(t0 + 1, 200, "jump_len_wait");
    checks++;
    if (tq[t0] !== 8'h15) begin errors++; $display("FAIL jump_len_nak: got %h expected 15", tq[t0]); end
    checks++;
    if (wq.size() - w0 !== 1 || wq[w0] !== {32'h0000_2000, 32'h1122_3344}) begin
      errors++; $display("FAIL jump_len_write: got %0d writes, %h expected 1, %h", wq.size() - w0, wq[w0], {32'h0000_2000, 32'h1122_3344});
    end
    checks++;
    if (go_cnt !== gc0 || boot_pc !== 32'h8000_0000) begin
      errors++; $display("FAIL jump_len_pc: got pulses=%0d pc=%h expected 0 80000000", go_cnt - gc0, boot_pc);
    end
  endtask

  task automatic test_garbage();
    int t0, w0, b0;
    t0 = tq.size(); b0 = busy_hi;
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h13);
    repeat (15) @(negedge clk);
    checks++;
    if (rd !== rx_q.size()) begin errors++; $display("FAIL garbage_drain: got %0d left expected 0", rx_q.size() - rd); end
    checks++;
    if (busy_hi !== b0 || tq.size() !== t0) begin
      errors++; $display("FAIL garbage_quiet: got busy cycles=%0d tx=%0d expected 0 0", busy_hi - b0, tq.size() - t0);
    end
    w0 = wq.size();
    push_pkt(8'h01, 32'h0000_4000, 8'd1, 32'hCAFE_F00D, 32'd0, 8'd0);
    wait_tx(t0 + 1, 200, "garbage_pkt_wait");
    checks++;
    if (tq[t0] !== 8'h06 || wq[w0] !== {32'h0000_4000, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL garbage_pkt: got tx=%h write=%h expected 06 %h", tq[t0], wq[w0], {32'h0000_4000, 32'hCAFE_F00D});
    end

    t0 = tq.size();
    push_byte(8'hA5); push_byte(8'h7F);
    wait_tx(t0 + 1, 100, "unknown_cmd_wait");
    checks++;
    if (tq[t0] !== 8'h15 || tx_lat !== 1) begin
      errors++; $display("FAIL unknown_cmd: got tx=%h latency=%0d expected 15 1", tq[t0], tx_lat);
    end
  endtask

  task automatic test_timeout();
    int t0, w0;
    t0 = tq.size(); w0 = wq.size();
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h00);
    wait_tx(t0 + 1, 400, "timeout_wait");
    checks++;
    if (tq[t0] !== 8'h15) begin errors++; $display("FAIL timeout_nak: got %h expected 15", tq[t0]); end
    // last pop cycle plus TMO starved cycles, response on the next one
    checks++;
    if (tx_lat !== TMO + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", tx_lat, TMO + 1); end
    t0 = tq.size();
    push_pkt(8'h01, 32'h0000_5000, 8'd1, 32'h5555_AAAA, 32'd0, 8'd0);
    wait_tx(t0 + 1, 200, "after_timeout_wait");
    checks++;
    if (tq[t0] !== 8'h06 || wq.size() - w0 !== 1) begin
      errors++; $display("FAIL after_timeout: got tx=%h writes=%0d expected 06 1", tq[t0], wq.size() - w0);
    end
  endtask

  task automatic test_reset_mid();
    int t0, w0, k;
    t0 = tq.size(); w0 = wq.size();
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h00); push_byte(8'h00);
    push_byte(8'h30); push_byte(8'h00); push_byte(8'h02); push_byte(8'hAA); push_byte(8'hBB);
    k = 0;
    while (rd < rx_q.size() && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_en, tx_en, mem_wen, boot_go, busy, tx_data, mem_addr, mem_wdata, boot_pc} !== 109'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {rx_en, tx_en, mem_wen, boot_go, busy, tx_data, mem_addr, mem_wdata, boot_pc});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (wq.size() !== w0 || tq.size() !== t0) begin
      errors++; $display("FAIL mid_reset_silent: got writes=%0d tx=%0d expected 0 0", wq.size() - w0, tq.size() - t0);
    end
    push_pkt(8'h01, 32'hFFFF_FFFC, 8'd2, 32'h0A0B_0C0D, 32'h1020_3040, 8'd0);
    wait_tx(t0 + 1, 400, "wrap_wait");
    checks++;
    if (tq[t0] !== 8'h06) begin errors++; $display("FAIL wrap_ack: got %h expected 06", tq[t0]); end
    checks++;
    if (wq[w0] !== {32'hFFFF_FFFC, 32'h0A0B_0C0D} || wq[w0+1] !== {32'h0000_0000, 32'h1020_3040}) begin
      errors++; $display("FAIL wrap_addr: got %h %h expected %h %h", wq[w0], wq[w0+1],
                         {32'hFFFF_FFFC, 32'h0A0B_0C0D}, {32'h0000_0000, 32'h1020_3040});
    end
  endtask

  initial begin
    test_reset();
    test_write_good();
    test_write_badsum();
    test_jump();
    test_garbage();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
